// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: reset PC, NOP
// encoding and the 2-bit branch-history counter with its update rule.
package fetch_stage_pkg;

    localparam logic [31:0] NOP_INSN         = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Saturating counter states; bit 1 set means "predict taken".
    typedef enum logic [1:0] {
        SNT = 2'd0,
        WNT = 2'd1,
        WT  = 2'd2,
        ST  = 2'd3
    } ctr_e;

    // Move one step towards the observed outcome, clamping at both ends.
    function automatic ctr_e ctr_step(input ctr_e cur, input logic taken);
        logic [1:0] val;
        val = cur;
        if (taken) begin
            if (cur != ST) val = val + 2'd1;
        end else begin
            if (cur != SNT) val = val - 2'd1;
        end
        return ctr_e'(val);
    endfunction

endpackage

// File: rtl/fetch_stage_btb.sv
// Direct-mapped branch target buffer. Lookup is purely combinational on
// the fetch PC; updates from EX land on the clock edge, so a lookup in the
// same cycle as an update to the same entry sees the old contents.
module branch_target_buffer
    import fetch_stage_pkg::*;
#(
    parameter int ENTRIES = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] lookup_pc_i,
    output logic        pred_taken_o,
    output logic [31:0] pred_target_o,
    input  logic        upd_valid_i,
    input  logic [31:0] upd_pc_i,
    input  logic        upd_taken_i,
    input  logic [31:0] upd_target_i
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX_W;

    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [29:0]      target_q [ENTRIES];
    ctr_e             ctr_q    [ENTRIES];

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_hit;
    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;
    logic             up_hit;

    // Instructions are word aligned, so the low address bits carry nothing.
    logic unused_low_bits;
    assign unused_low_bits = ^{lookup_pc_i[1:0], upd_pc_i[1:0], upd_target_i[1:0]};

    assign lk_idx = lookup_pc_i[IDX_W+1:2];
    assign lk_tag = lookup_pc_i[31:IDX_W+2];
    assign up_idx = upd_pc_i[IDX_W+1:2];
    assign up_tag = upd_pc_i[31:IDX_W+2];

    // Lookup: only a tag hit with a taken-leaning counter predicts taken.
    always_comb begin
        lk_hit        = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        pred_taken_o  = lk_hit && ctr_q[lk_idx][1];
        pred_target_o = {target_q[lk_idx], 2'b00};
        up_hit        = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    end

    generate
        for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
            // Per-entry state: train on a hit, allocate on a taken miss.
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    valid_q[gi]  <= 1'b0;
                    tag_q[gi]    <= '0;
                    target_q[gi] <= '0;
                    ctr_q[gi]    <= SNT;
                end else if (upd_valid_i && (up_idx == IDX_W'(gi))) begin
                    if (up_hit) begin
                        ctr_q[gi] <= ctr_step(ctr_q[gi], upd_taken_i);
                        if (upd_taken_i) target_q[gi] <= upd_target_i[31:2];
                    end else if (upd_taken_i) begin
                        valid_q[gi]  <= 1'b1;
                        tag_q[gi]    <= up_tag;
                        target_q[gi] <= upd_target_i[31:2];
                        ctr_q[gi]    <= WT;
                    end
                end
            end
        end
    endgenerate

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses instruction memory and
// steers the next fetch using EX redirects, stalls and BTB predictions.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
    parameter int          BTB_ENTRIES = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        upd_valid_i,
    input  logic [31:0] upd_pc_i,
    input  logic        upd_taken_i,
    input  logic [31:0] upd_target_i,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] instruction_o,
    output logic [31:0] pc_o,
    output logic        br_pred_o
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic        pred_taken;
    logic [31:0] pred_target;

    logic unused_redirect_low;
    assign unused_redirect_low = ^redirect_pc_i[1:0];

    branch_target_buffer #(
        .ENTRIES(BTB_ENTRIES)
    ) u_btb (
        .clk          (clk),
        .reset_n      (reset_n),
        .lookup_pc_i  (pc_q),
        .pred_taken_o (pred_taken),
        .pred_target_o(pred_target),
        .upd_valid_i  (upd_valid_i),
        .upd_pc_i     (upd_pc_i),
        .upd_taken_i  (upd_taken_i),
        .upd_target_i (upd_target_i)
    );

    // Next-PC select: EX redirect beats stall, stall beats prediction.
    always_comb begin
        pc_d = pc_q + 32'd4;
        if (redirect_i) begin
            pc_d = {redirect_pc_i[31:2], 2'b00};
        end else if (stall_i) begin
            pc_d = pc_q;
        end else if (pred_taken) begin
            pc_d = pred_target;
        end
    end

    // PC register; reset wins over every other input.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc_q <= {RESET_PC[31:2], 2'b00};
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o          = pc_q;
    assign imem_addr_o   = pc_q;
    assign instruction_o = imem_rdata_i;
    assign br_pred_o     = pred_taken;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a reference model of PC and BTB
// pushes the expected post-edge state into a queue, popped after each edge.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        upd_valid_i;
    logic [31:0] upd_pc_i;
    logic        upd_taken_i;
    logic [31:0] upd_target_i;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_rdata_i;
    logic [31:0] instruction_o;
    logic [31:0] pc_o;
    logic        br_pred_o;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] pc;
        logic        pred;
    } exp_t;
    exp_t exp_q[$];

    // Reference model state (64 entries, 6 index bits, 24 tag bits)
    logic        m_valid [64];
    logic [23:0] m_tag   [64];
    logic [31:0] m_tgt   [64];
    logic [1:0]  m_ctr   [64];
    logic [31:0] m_pc;

    always #5 clk = ~clk;

    function automatic logic [31:0] imem_f(input logic [31:0] a);
        return {a[29:0], 2'b11} ^ 32'hA5A5_0000;
    endfunction

    assign imem_rdata_i = imem_f(imem_addr_o);

    fetch_stage dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .stall_i      (stall_i),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .upd_valid_i  (upd_valid_i),
        .upd_pc_i     (upd_pc_i),
        .upd_taken_i  (upd_taken_i),
        .upd_target_i (upd_target_i),
        .imem_addr_o  (imem_addr_o),
        .imem_rdata_i (imem_rdata_i),
        .instruction_o(instruction_o),
        .pc_o         (pc_o),
        .br_pred_o    (br_pred_o)
    );

    function automatic logic m_pred(input logic [31:0] a);
        logic [5:0] i;
        i = a[7:2];
        return m_valid[i] && (m_tag[i] == a[31:8]) && m_ctr[i][1];
    endfunction

    // Drive one cycle, advance the model, then compare after the edge.
    task automatic drive_cycle(input logic rn, input logic st, input logic rd,
                               input logic [31:0] rpc, input logic uv,
                               input logic [31:0] upc, input logic ut,
                               input logic [31:0] utg);
        exp_t        e;
        logic [31:0] npc;
        logic [5:0]  i;
        logic        hit;
        reset_n = rn; stall_i = st; redirect_i = rd; redirect_pc_i = rpc;
        upd_valid_i = uv; upd_pc_i = upc; upd_taken_i = ut; upd_target_i = utg;
        if (!rn) begin
            m_pc = 32'h0;
            for (int k = 0; k < 64; k++) begin
                m_valid[k] = 1'b0;
                m_ctr[k]   = 2'd0;
            end
        end else begin
            if (rd)                npc = rpc & 32'hFFFF_FFFC;
            else if (st)           npc = m_pc;
            else if (m_pred(m_pc)) npc = m_tgt[m_pc[7:2]];
            else                   npc = m_pc + 32'd4;
            if (uv) begin
                i   = upc[7:2];
                hit = m_valid[i] && (m_tag[i] == upc[31:8]);
                if (hit) begin
                    if (ut) begin
                        if (m_ctr[i] != 2'd3) m_ctr[i] = m_ctr[i] + 2'd1;
                        m_tgt[i] = utg & 32'hFFFF_FFFC;
                    end else if (m_ctr[i] != 2'd0) begin
                        m_ctr[i] = m_ctr[i] - 2'd1;
                    end
                end else if (ut) begin
                    m_valid[i] = 1'b1;
                    m_tag[i]   = upc[31:8];
                    m_tgt[i]   = utg & 32'hFFFF_FFFC;
                    m_ctr[i]   = 2'd2;
                end
            end
            m_pc = npc;
        end
        e.pc   = m_pc;
        e.pred = m_pred(m_pc);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL scoreboard_empty got=%0d want=1", exp_q.size());
        end else begin
            e = exp_q.pop_front();
            if (pc_o !== e.pc) begin
                bad++;
                $display("FAIL sb_pc got=%h want=%h", pc_o, e.pc);
            end
            total++;
            if (imem_addr_o !== e.pc) begin
                bad++;
                $display("FAIL sb_imem_addr got=%h want=%h", imem_addr_o, e.pc);
            end
            total++;
            if (br_pred_o !== e.pred) begin
                bad++;
                $display("FAIL sb_pred pc=%h got=%b want=%b", e.pc, br_pred_o, e.pred);
            end
            total++;
            if (instruction_o !== imem_f(e.pc)) begin
                bad++;
                $display("FAIL sb_insn got=%h want=%h", instruction_o, imem_f(e.pc));
            end
        end
        $display("cycle rn=%b st=%b rd=%b rpc=%h uv=%b upc=%h ut=%b utg=%h -> pc=%h pred=%b",
                 rn, st, rd, rpc, uv, upc, ut, utg, pc_o, br_pred_o);
    endtask

    task automatic plain();
        drive_cycle(1, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    endtask

    task automatic redirect_to(input logic [31:0] a);
        drive_cycle(1, 0, 1, a, 0, 32'h0, 0, 32'h0);
    endtask

    task automatic stalled_update(input logic [31:0] upc, input logic ut, input logic [31:0] utg);
        drive_cycle(1, 1, 0, 32'h0, 1, upc, ut, utg);
    endtask

    task automatic test_reset();
        drive_cycle(0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
        drive_cycle(0, 1, 1, 32'h1234, 1, 32'h0, 1, 32'h40);
        total++;
        if (pc_o !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h want=%h", pc_o, 32'h0); end
        total++;
        if (br_pred_o !== 1'b0) begin bad++; $display("FAIL reset_pred got=%b want=0", br_pred_o); end
    endtask

    task automatic test_sequential();
        logic [31:0] want;
        for (int k = 1; k <= 3; k++) begin
            plain();
            want = 32'(k * 4);
            total++;
            if (pc_o !== want) begin bad++; $display("FAIL seq_pc got=%h want=%h", pc_o, want); end
            total++;
            if (br_pred_o !== 1'b0) begin bad++; $display("FAIL seq_pred got=%b want=0", br_pred_o); end
        end
    endtask

    task automatic test_train();
        drive_cycle(1, 0, 0, 32'h0, 1, 32'h10, 1, 32'h40);
        total++;
        if (pc_o !== 32'h10 || br_pred_o !== 1'b1) begin
            bad++; $display("FAIL train_hit got=%h/%b want=00000010/1", pc_o, br_pred_o);
        end
        plain();
        total++;
        if (pc_o !== 32'h40) begin bad++; $display("FAIL train_target got=%h want=%h", pc_o, 32'h40); end
        stalled_update(32'h10, 0, 32'h0);
        stalled_update(32'h10, 0, 32'h0);
        redirect_to(32'h10);
        total++;
        if (br_pred_o !== 1'b0) begin bad++; $display("FAIL train_untrain got=%b want=0", br_pred_o); end
        plain();
        total++;
        if (pc_o !== 32'h14) begin bad++; $display("FAIL train_fallthru got=%h want=%h", pc_o, 32'h14); end
    endtask

    task automatic test_stall();
        redirect_to(32'h8);
        for (int k = 0; k < 3; k++) begin
            drive_cycle(1, 1, 0, 32'h0, 0, 32'h0, 0, 32'h0);
            total++;
            if (pc_o !== 32'h8) begin bad++; $display("FAIL stall_hold got=%h want=%h", pc_o, 32'h8); end
        end
        drive_cycle(1, 1, 1, 32'h203, 0, 32'h0, 0, 32'h0);
        total++;
        if (pc_o !== 32'h200) begin bad++; $display("FAIL stall_redirect got=%h want=%h", pc_o, 32'h200); end
    endtask

    task automatic test_saturation();
        for (int k = 0; k < 5; k++) stalled_update(32'h300, 1, 32'h500);
        stalled_update(32'h300, 0, 32'h0);
        redirect_to(32'h300);
        total++;
        if (br_pred_o !== 1'b1) begin bad++; $display("FAIL sat_pred got=%b want=1", br_pred_o); end
        plain();
        total++;
        if (pc_o !== 32'h500) begin bad++; $display("FAIL sat_target got=%h want=%h", pc_o, 32'h500); end
        stalled_update(32'h400, 1, 32'h602);
        redirect_to(32'h300);
        total++;
        if (br_pred_o !== 1'b0) begin bad++; $display("FAIL alias_old got=%b want=0", br_pred_o); end
        redirect_to(32'h400);
        total++;
        if (br_pred_o !== 1'b1) begin bad++; $display("FAIL alias_new got=%b want=1", br_pred_o); end
        plain();
        total++;
        if (pc_o !== 32'h600) begin bad++; $display("FAIL alias_target got=%h want=%h", pc_o, 32'h600); end
    endtask

    task automatic test_same_cycle();
        redirect_to(32'h80);
        drive_cycle(1, 0, 0, 32'h0, 1, 32'h80, 1, 32'hC0);
        total++;
        if (pc_o !== 32'h84) begin bad++; $display("FAIL rbw_old got=%h want=%h", pc_o, 32'h84); end
        redirect_to(32'h80);
        total++;
        if (br_pred_o !== 1'b1) begin bad++; $display("FAIL rbw_new got=%b want=1", br_pred_o); end
    endtask

    task automatic test_reset_midrun();
        drive_cycle(0, 0, 1, 32'h700, 1, 32'h80, 1, 32'h900);
        total++;
        if (pc_o !== 32'h0 || br_pred_o !== 1'b0) begin
            bad++; $display("FAIL midreset got=%h/%b want=00000000/0", pc_o, br_pred_o);
        end
        redirect_to(32'h80);
        total++;
        if (br_pred_o !== 1'b0) begin bad++; $display("FAIL midreset_80 got=%b want=0", br_pred_o); end
        redirect_to(32'h400);
        total++;
        if (br_pred_o !== 1'b0) begin bad++; $display("FAIL midreset_400 got=%b want=0", br_pred_o); end
    endtask

    task automatic test_back_to_back();
        logic        st, rd, uv, ut, rn;
        logic [31:0] rpc, upc, utg;
        for (int k = 0; k < 300; k++) begin
            rn  = ($urandom_range(0, 99) != 0);
            st  = ($urandom_range(0, 4) == 0);
            rd  = ($urandom_range(0, 6) == 0);
            rpc = {22'($urandom_range(0, 2)), 8'($urandom), 2'($urandom)};
            uv  = ($urandom_range(0, 2) != 0);
            upc = {22'($urandom_range(0, 2)), 6'($urandom), 2'b00, 2'($urandom)};
            ut  = ($urandom_range(0, 2) != 0);
            utg = {22'($urandom_range(0, 2)), 8'($urandom), 2'($urandom)};
            drive_cycle(rn, st, rd, rpc, uv, upc, ut, utg);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
        upd_valid_i = 1'b0; upd_pc_i = '0; upd_taken_i = 1'b0; upd_target_i = '0;
        for (int k = 0; k < 64; k++) begin
            m_valid[k] = 1'b0; m_tag[k] = '0; m_tgt[k] = '0; m_ctr[k] = '0;
        end
        m_pc = 32'h0;
        @(posedge clk);
        #1;
        test_reset();
        test_sequential();
        test_train();
        test_stall();
        test_saturation();
        test_same_cycle();
        test_reset_midrun();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
